// File: rtl/alu_op_pkg.sv
// Operation codes, FSM state type and width default shared by the ALU execute unit.
package alu_op_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  // Codes exactly as driven by the ALU control decoder
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_DEF  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_ORI  = 4'b1000;
  localparam logic [3:0] OP_LUI  = 4'b1001;
  localparam logic [3:0] OP_JALR = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_LW   = 4'b1101;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_BLT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic f_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for SLL/SRL: one bit per cycle by default, combinational barrel shifter
// when ALU_BARREL_SHIFT_EN is defined. o_done marks the cycle o_result is final.
module alu_shift_unit
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int SHW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  i_start,
  input  logic                  i_left,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [SHW-1:0]        i_amt,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unused;
  assign w_unused = ^{clk_i, reset_i};

  assign o_done   = i_start;
  assign o_result = i_left ? (i_a << i_amt) : (i_a >> i_amt);

`else

  logic                  r_busy;
  logic [SHW-1:0]        r_cnt;
  logic                  r_left;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] w_step;

  assign w_step = r_left ? {r_work[DATA_WIDTH-2:0], 1'b0} : {1'b0, r_work[DATA_WIDTH-1:1]};

  // A zero count finishes in the start cycle with the operand passed through
  assign o_done   = (i_start && (i_amt == '0)) || (r_busy && (r_cnt == SHW'(1)));
  assign o_result = r_busy ? w_step : i_a;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && (i_amt != '0)) begin
      r_busy <= 1'b1;
      r_cnt  <= i_amt;
    end else if (r_busy) begin
      r_cnt <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_start) begin
      r_work <= i_a;
      r_left <= i_left;
    end else if (r_busy) begin
      r_work <= w_step;
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; shifts are iterative unless
// ALU_BARREL_SHIFT_EN is defined, in which case every op completes in one cycle.
module alu_exec_unit
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  illegal_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;

  logic                  w_accept;
  logic                  w_is_shift;
  logic                  w_sh_start;
  logic                  w_sh_done;
  logic [DATA_WIDTH-1:0] w_sh_result;

  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic signed [DATA_WIDTH-1:0] w_a_s;
  logic signed [DATA_WIDTH-1:0] w_b_s;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_branch;
  logic                  w_taken;
  logic                  w_illegal;
  logic                  w_zero;

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = (r_state == ST_DONE);
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign illegal_o   = r_illegal;

  assign w_accept   = in_valid_i && (r_state == ST_IDLE);
  assign w_is_shift = f_is_shift(alu_operation_i);
  assign w_sh_start = w_accept && w_is_shift;

  alu_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHW        (SHW)
  ) u_shift (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_start  (w_sh_start),
    .i_left   (alu_operation_i == OP_SLL),
    .i_a      (a_i),
    .i_amt    (b_i[SHW-1:0]),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

  assign w_sum  = a_i + b_i;
  assign w_diff = a_i - b_i;
  assign w_a_s  = a_i;
  assign w_b_s  = b_i;

  always_comb begin
    w_res     = '0;
    w_branch  = 1'b0;
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (alu_operation_i)
      OP_ADD, OP_SW, OP_LW: w_res = w_sum;
      OP_SUB:               w_res = w_diff;
      OP_XOR:               w_res = a_i ^ b_i;
      OP_OR, OP_ORI:        w_res = a_i | b_i;
      OP_AND:               w_res = a_i & b_i;
      OP_SLL, OP_SRL:       w_res = w_sh_result;
      OP_LUI:               w_res = b_i;
      OP_JALR:              w_res = {w_sum[DATA_WIDTH-1:1], 1'b0};
      OP_BEQ: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_taken  = (a_i == b_i);
      end
      OP_BNE: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_taken  = (a_i != b_i);
      end
      OP_BLT: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_taken  = (w_a_s < w_b_s);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_zero = w_illegal ? 1'b0 : (w_branch ? w_taken : (w_res == '0));

  // Outputs are only written on entry to DONE, so they hold through SHIFT and DONE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            if (w_is_shift && !w_sh_done) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state   <= ST_DONE;
              r_result  <= w_res;
              r_zero    <= w_zero;
              r_illegal <= w_illegal;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          if (w_sh_done) begin
            r_state   <= ST_DONE;
            r_result  <= w_sh_result;
            r_zero    <= (w_sh_result == '0);
            r_illegal <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases followed by random ops against a table-driven reference.
module tb_alu_exec_unit;

  localparam int W = 32;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [3:0]   alu_operation_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         illegal_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic         ill;
    logic         zero;
    logic [W-1:0] res;
  } exp_t;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .illegal_o       (illegal_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b % W);
    e.ill = 1'b0;
    e.res = '0;
    case (op)
      4'b0000, 4'b1100, 4'b1101: e.res = a + b;
      4'b0001: e.res = a - b;
      4'b0010: e.res = a ^ b;
      4'b0011, 4'b1000: e.res = a | b;
      4'b0100: e.res = a & b;
      4'b0101: e.res = a << sh;
      4'b0111: e.res = a >> sh;
      4'b1001: e.res = b;
      4'b1010: e.res = (a + b) & ~W'(1);
      4'b1011, 4'b1110, 4'b1111: e.res = a - b;
      default: e.ill = 1'b1;
    endcase
    if (e.ill)              e.zero = 1'b0;
    else if (op == 4'b1011) e.zero = (a == b);
    else if (op == 4'b1110) e.zero = (a != b);
    else if (op == 4'b1111) e.zero = ($signed(a) < $signed(b));
    else                    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (!BARREL && (op == 4'b0101 || op == 4'b0111)) return int'(b % W);
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request and returns #1 after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("in_ready_idle", W'(in_ready_o), W'(1));
    in_valid_i      = 1'b1;
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    @(posedge clk);
    #1;
    in_valid_i      = 1'b0;
    a_i             = $urandom;
    b_i             = $urandom;
    alu_operation_i = 4'($urandom);
  endtask

  task automatic wait_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] prev);
    exp_t e;
    int   k;
    e = model(op, a, b);
    k = 0;
    while (!out_valid_o && k < 40) begin
      chk({tag, "_hold"}, result_o, prev);
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_latency"}, W'(k), W'(exp_lat(op, b)));
    chk({tag, "_result"}, result_o, e.res);
    chk({tag, "_zero"}, W'(zero_o), W'(e.zero));
    chk({tag, "_illegal"}, W'(illegal_o), W'(e.ill));
    chk({tag, "_ready_busy"}, W'(in_ready_o), W'(0));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, W'(out_valid_o), W'(0));
    chk({tag, "_ready_back"}, W'(in_ready_o), W'(1));
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] prev;
    prev = result_o;
    issue(op, a, b);
    wait_check(tag, op, a, b, prev);
    release_out(tag);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset_i         = 1'b1;
    in_valid_i      = 1'b0;
    out_ready_i     = 1'b0;
    alu_operation_i = 4'b0000;
    a_i             = '0;
    b_i             = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    chk("rst_ready", W'(in_ready_o), W'(1));
    chk("rst_valid", W'(out_valid_o), W'(0));
    chk("rst_result", result_o, W'(0));
    chk("rst_zero", W'(zero_o), W'(0));
    chk("rst_illegal", W'(illegal_o), W'(0));

    run("add", 4'b0000, 32'd5, 32'd7);
    run("sub_eq", 4'b0001, 32'd7, 32'd7);
    run("sll31", 4'b0101, 32'd1, 32'd31);
    run("srl0", 4'b0111, 32'h8000_0000, 32'd0);
    run("srl5", 4'b0111, 32'hF000_0000, 32'd5);
    run("blt", 4'b1111, 32'hFFFF_FFFF, 32'd1);
    run("bne", 4'b1110, 32'd3, 32'd3);
    run("beq", 4'b1011, 32'd3, 32'd3);
    run("jalr", 4'b1010, 32'h1000, 32'd5);
    run("lui", 4'b1001, 32'd0, 32'hABCD_E000);
    run("illegal", 4'b0110, 32'h1234, 32'h5678);
    run("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd2);

    // Backpressure: DONE holds while a competing request is presented
    issue(4'b0000, 32'd5, 32'd7);
    wait_check("bp", 4'b0000, 32'd5, 32'd7, result_o);
    held = result_o;
    @(negedge clk);
    in_valid_i      = 1'b1;
    alu_operation_i = 4'b0001;
    a_i             = 32'd9;
    b_i             = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", W'(out_valid_o), W'(1));
      chk("bp_ready", W'(in_ready_o), W'(0));
      chk("bp_result", result_o, held);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    release_out("bp");
    chk("bp_not_taken", result_o, held);

    // Reset during a long shift aborts it
    issue(4'b0101, 32'd1, 32'd20);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_pre_valid", W'(out_valid_o), W'(BARREL));
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", W'(out_valid_o), W'(0));
    chk("abort_result", result_o, W'(0));
    chk("abort_zero", W'(zero_o), W'(0));
    chk("abort_illegal", W'(illegal_o), W'(0));
    @(negedge clk);
    reset_i = 1'b0;
    chk("abort_ready", W'(in_ready_o), W'(1));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_emit", W'(out_valid_o), W'(0));
    end

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run("rand", rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
